pupil_frame_streamer: RTL and testbench
=======================================

// Module: pupil_frame_streamer
// PURPOSE
//  Raster-scan reader for the eye-image frame buffer. On each start request it reads one
//  IMG_W x IMG_H frame from synchronous RAM and streams it downstream to the pupil centroid
//  stage. Each pixel carries its linear address, X/Y coordinates and frame markers, under
//  valid/ready flow control.
// PARAMETERS
//  IMG_W   320  pixels per line
//  IMG_H   240  lines per frame
//  ADDR_W  20   RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
//  DATA_W  8    pixel width
//  THRESH  40   binarisation threshold, used only when PUPIL_STREAM_THRESH_EN is defined
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-low
//  start      in   1       one-cycle frame request; honoured only in IDLE
//  busy       out  1       high from accepted start until done
//  done       out  1       one-cycle pulse after the final pixel handshake
//  mem_rd_en  out  1       RAM read strobe
//  mem_addr   out  ADDR_W  RAM read address
//  mem_rdata  in   DATA_W  RAM data, valid exactly 1 clk after mem_rd_en
//  out_valid  out  1       output pixel valid
//  out_ready  in   1       downstream accept
//  out_data   out  DATA_W  pixel value (thresholded if macro defined)
//  out_addr   out  ADDR_W  linear address of the pixel, y*IMG_W+x
//  out_x      out  10      column, 0..IMG_W-1
//  out_y      out  10      row, 0..IMG_H-1
//  out_sof    out  1       high with pixel (0,0)
//  out_eof    out  1       high with pixel (IMG_W-1, IMG_H-1)
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge) forces every output to 0, the FSM to IDLE and all
//    counters to 0, flushes the FIFO and discards any in-flight read. This applies
//    mid-frame too; no done pulse is produced.
//  - FSM states: IDLE -> STREAM when start=1. STREAM -> DRAIN when the read of address
//    IMG_W*IMG_H-1 is issued. DRAIN -> IDLE after the last pixel handshake; done=1 on the
//    following cycle. start is ignored while busy.
//  - Handshake: a transfer occurs when out_valid & out_ready. While out_valid=1 and
//    out_ready=0, out_valid and all out_* fields hold stable.
//  - Buffering: 2-entry output FIFO plus credit logic.
//    - A read is issued in a cycle iff state==STREAM and occupancy + in_flight - pop < 2,
//      where pop is the current-cycle handshake.
//    - Returned data is written to the FIFO on the cycle it arrives.
//    - The FIFO never overflows and no RAM data is ever dropped.
//  - Latency and throughput:
//    - Read of address 0 is issued the cycle after start is sampled.
//    - First out_valid is asserted 3 clks after the start edge.
//    - Sustains 1 pixel/clk while out_ready=1, so a full frame takes IMG_W*IMG_H+3 clks
//      from start to done.
//  - Addressing:
//    - The read address increments by 1 per read, from 0 to IMG_W*IMG_H-1.
//    - The read-side x counter wraps from IMG_W-1 to 0 and increments y at the wrap.
//    - Coordinates travel with the data through the FIFO, so out_x/out_y/out_addr always
//      match out_data.
//  - Arithmetic: coordinates are 10-bit unsigned; out_addr is zero-extended to ADDR_W.
//  - start arriving on the same cycle as done is ignored; a new frame needs start in IDLE.
// CONFIGURATION
//  PUPIL_STREAM_THRESH_EN defined:
//    - out_data = 0 when mem_rdata < THRESH, else {DATA_W{1'b1}}.
//    - Compare is registered at FIFO write; latency is unchanged.
//  PUPIL_STREAM_THRESH_EN undefined: out_data = raw mem_rdata; THRESH is unused.
// TESTING
//  1. IMG_W=4, IMG_H=3, RAM[i]=i, out_ready=1, start pulse at cycle 0:
//     - out_valid first at cycle 3 with x=0, y=0, sof=1.
//     - 12 consecutive beats, data 0..11.
//     - beat 11 has x=3, y=2, eof=1.
//     - done at cycle 15; busy low after.
//  2. Same frame with out_ready toggling 1,0,0,1 repeatedly:
//     - all 12 beats delivered in order, none lost or duplicated.
//     - fields stable while stalled; mem_rd_en never issued with occupancy+in_flight=2.
//  3. out_ready=0 for 20 clks after start:
//     - exactly 2 reads issued, then mem_rd_en stays 0.
//     - on release, beats 0,1 are delivered, then streaming resumes.
//  4. start re-pulsed while busy at beat 5:
//     - ignored; frame completes with exactly 12 beats and a single done.
//  5. reset=0 asserted at beat 6 of frame 1:
//     - next cycle all outputs 0; no done.
//     - a new start streams from address 0 with sof=1.
//  6. PUPIL_STREAM_THRESH_EN defined, THRESH=40, RAM = {39, 40, 0, 255}:
//     - out_data = 0x00, 0xFF, 0x00, 0xFF.
//     - without the macro, out_data = 39, 40, 0, 255.

Source files
------------

// File: rtl/pupil_frame_streamer.sv
// Raster-scan frame-buffer reader streaming pixels with coordinates under valid/ready.
// Optional binarisation of pixel data when PUPIL_STREAM_THRESH_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start (ignored in the cycle done is high)
// STREAM | issuing RAM reads as FIFO credit allows
// DRAIN  | all reads issued, emptying FIFO until the last pixel handshakes
module pupil_frame_streamer #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8,
    parameter int THRESH = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic              out_sof,
    output logic              out_eof
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [9:0]        X_LAST    = 10'(IMG_W - 1);

`ifdef PUPIL_STREAM_THRESH_EN
    localparam bit THRESH_ON = 1'b1;
`else
    localparam bit THRESH_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] rd_addr;
    logic [9:0]        rd_x, rd_y;
    logic              in_flight;
    logic [ADDR_W-1:0] fl_addr;
    logic [9:0]        fl_x, fl_y;

    logic [1:0]        count;
    logic              wr_ptr, rd_ptr;
    logic [DATA_W-1:0] f_data [2];
    logic [ADDR_W-1:0] f_addr [2];
    logic [9:0]        f_x    [2];
    logic [9:0]        f_y    [2];
    logic              f_sof  [2];
    logic              f_eof  [2];

    logic              pop;
    logic              last_rd;
    logic [2:0]        credit_used;
    logic [DATA_W-1:0] pix_in;

    assign out_valid   = (count != 2'd0);
    assign pop         = out_valid & out_ready;
    assign out_data    = f_data[rd_ptr];
    assign out_addr    = f_addr[rd_ptr];
    assign out_x       = f_x[rd_ptr];
    assign out_y       = f_y[rd_ptr];
    assign out_sof     = f_sof[rd_ptr];
    assign out_eof     = f_eof[rd_ptr];
    assign busy        = (state != IDLE);
    assign mem_addr    = rd_addr;
    assign last_rd     = (rd_addr == LAST_ADDR);
    // Slots already committed after this cycle's pop; a read needs one free slot.
    assign credit_used = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};

    always_comb begin
        pix_in = mem_rdata;
        if (THRESH_ON) begin
            pix_in = (mem_rdata < DATA_W'(THRESH)) ? '0 : '1;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) state_nxt = STREAM;
            end
            STREAM: begin
                mem_rd_en = (credit_used < 3'd2);
                if (mem_rd_en && last_rd) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && out_eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            rd_addr   <= '0;
            rd_x      <= '0;
            rd_y      <= '0;
            in_flight <= 1'b0;
            fl_addr   <= '0;
            fl_x      <= '0;
            fl_y      <= '0;
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                f_data[i] <= '0;
                f_addr[i] <= '0;
                f_x[i]    <= '0;
                f_y[i]    <= '0;
                f_sof[i]  <= 1'b0;
                f_eof[i]  <= 1'b0;
            end
        end else begin
            state     <= state_nxt;
            done      <= (state == DRAIN) && pop && out_eof;
            in_flight <= mem_rd_en;
            // Read-side counters wrap to 0 after the last pixel so IDLE presents address 0.
            if (mem_rd_en) begin
                fl_addr <= rd_addr;
                fl_x    <= rd_x;
                fl_y    <= rd_y;
                if (last_rd) begin
                    rd_addr <= '0;
                    rd_x    <= '0;
                    rd_y    <= '0;
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    if (rd_x == X_LAST) begin
                        rd_x <= '0;
                        rd_y <= rd_y + 10'd1;
                    end else begin
                        rd_x <= rd_x + 10'd1;
                    end
                end
            end
            if (in_flight) begin
                f_data[wr_ptr] <= pix_in;
                f_addr[wr_ptr] <= fl_addr;
                f_x[wr_ptr]    <= fl_x;
                f_y[wr_ptr]    <= fl_y;
                f_sof[wr_ptr]  <= (fl_x == 10'd0) && (fl_y == 10'd0);
                f_eof[wr_ptr]  <= (fl_addr == LAST_ADDR);
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_flight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_pupil_frame_streamer.sv
// Scoreboard bench for pupil_frame_streamer on a 4x3 frame; honours PUPIL_STREAM_THRESH_EN.
`timescale 1ns/1ps
module tb_pupil_frame_streamer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [9:0]        x;
        logic [9:0]        y;
        logic              sof;
        logic              eof;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy, done, mem_rd_en, out_valid, out_sof, out_eof;
    logic [ADDR_W-1:0] mem_addr, out_addr;
    logic [DATA_W-1:0] mem_rdata, out_data;
    logic [9:0]        out_x, out_y;
    logic [DATA_W-1:0] ram [16];

    beat_t             exp_q [$];
    beat_t             cur, prev_beat;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] log_data [NPIX];
    int n_vec = 0, n_err = 0, cyc = 0, c0 = 0;
    int beat_cnt = 0, done_cnt = 0, rd_cnt = 0, outstanding = 0;
    int first_valid_rel = -1, done_rel = -1;

    pupil_frame_streamer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .THRESH(40)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eof(out_eof)
    );

    assign cur = {out_data, out_addr, out_x, out_y, out_sof, out_eof};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_pix(input logic [DATA_W-1:0] v);
`ifdef PUPIL_STREAM_THRESH_EN
        return (v < 8'd40) ? 8'h00 : 8'hFF;
`else
        return v;
`endif
    endfunction

    // Monitor: scoreboard pops, stall stability, credit limit, done/first-valid timing.
    always @(negedge clk) begin
        logic  pop_now;
        beat_t e;
        pop_now = out_valid && out_ready;
        if (reset && prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_fields", cur, prev_beat);
        end
        if (mem_rd_en === 1'b1) begin
            rd_cnt++;
            chk("credit", ((outstanding - int'(pop_now)) < 2), 1);
        end
        if (pop_now) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", cur, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("beat", cur, e);
            end
            if (beat_cnt < NPIX) log_data[beat_cnt] = out_data;
            beat_cnt++;
        end
        if (out_valid && first_valid_rel < 0) first_valid_rel = cyc - c0;
        if (done) begin
            done_cnt++;
            done_rel = cyc - c0;
        end
        outstanding = outstanding + int'(mem_rd_en === 1'b1) - int'(pop_now);
        if (!reset) outstanding = 0;
        prev_stall = reset && out_valid && !out_ready;
        prev_beat  = cur;
    end

    task automatic push_frame();
        beat_t b;
        for (int i = 0; i < NPIX; i++) begin
            b.data = exp_pix(ram[i]);
            b.addr = ADDR_W'(i);
            b.x    = 10'(i % IMG_W);
            b.y    = 10'(i / IMG_W);
            b.sof  = (i == 0);
            b.eof  = (i == NPIX - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_frame();
        beat_cnt = 0;
        first_valid_rel = -1;
        done_rel = -1;
        rd_cnt = 0;
        push_frame();
        @(posedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input bit toggle, input string name);
        int n;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        n = 0;
        while (done_cnt == base && n < 300) begin
            if (toggle) out_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        chk(name, done_cnt, base + 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        logic [DATA_W-1:0] exp6 [4];

        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {busy, done, mem_rd_en, out_valid}, 0);
        chk("rst_fields", {mem_addr, cur}, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: straight frame with out_ready held high
        out_ready = 1'b1;
        base = done_cnt;
        start_frame();
        wait_done(base, 1'b0, "t1_done");
        chk("t1_first_valid_cycle", 64'(first_valid_rel), 3);
        chk("t1_done_cycle", 64'(done_rel), 15);
        chk("t1_beats", 64'(beat_cnt), 12);
        chk("t1_busy_after", busy, 0);
        chk("t1_queue_empty", 64'(exp_q.size()), 0);
        repeat (5) @(posedge clk);
        #1 chk("t1_single_done", 64'(done_cnt), 64'(base + 1));

        // 2: out_ready toggling 1,0,0,1
        base = done_cnt;
        start_frame();
        wait_done(base, 1'b1, "t2_done");
        chk("t2_beats", 64'(beat_cnt), 12);
        chk("t2_queue_empty", 64'(exp_q.size()), 0);

        // 3: back-pressure for 20 clocks after start
        out_ready = 1'b0;
        base = done_cnt;
        start_frame();
        repeat (19) @(posedge clk);
        #1;
        chk("t3_reads_while_stalled", 64'(rd_cnt), 2);
        chk("t3_valid_while_stalled", out_valid, 1);
        chk("t3_head_x", out_x, 0);
        out_ready = 1'b1;
        wait_done(base, 1'b0, "t3_done");
        chk("t3_beats", 64'(beat_cnt), 12);
        chk("t3_reads_total", 64'(rd_cnt), 12);

        // 4: start re-pulsed mid-frame
        base = done_cnt;
        start_frame();
        n = 0;
        while (beat_cnt < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(base, 1'b0, "t4_done");
        repeat (20) @(posedge clk);
        #1;
        chk("t4_single_done", 64'(done_cnt), 64'(base + 1));
        chk("t4_beats", 64'(beat_cnt), 12);
        chk("t4_busy_after", busy, 0);
        chk("t4_queue_empty", 64'(exp_q.size()), 0);

        // 5: reset mid-frame, then a fresh frame
        base = done_cnt;
        start_frame();
        n = 0;
        while (beat_cnt < 6 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_rst_ctrl", {busy, done, mem_rd_en, out_valid}, 0);
        chk("t5_rst_fields", {mem_addr, cur}, 0);
        repeat (20) @(posedge clk);
        #1 chk("t5_no_done", 64'(done_cnt), 64'(base));
        base = done_cnt;
        start_frame();
        wait_done(base, 1'b0, "t5_done");
        chk("t5_beats", 64'(beat_cnt), 12);
        chk("t5_first_valid_cycle", 64'(first_valid_rel), 3);

        // 6: threshold boundary values
        ram[0] = 8'd39; ram[1] = 8'd40; ram[2] = 8'd0; ram[3] = 8'd255;
        for (int i = 4; i < 16; i++) ram[i] = 8'(100 + i);
`ifdef PUPIL_STREAM_THRESH_EN
        exp6[0] = 8'h00; exp6[1] = 8'hFF; exp6[2] = 8'h00; exp6[3] = 8'hFF;
`else
        exp6[0] = 8'd39; exp6[1] = 8'd40; exp6[2] = 8'd0; exp6[3] = 8'd255;
`endif
        base = done_cnt;
        start_frame();
        wait_done(base, 1'b0, "t6_done");
        for (int i = 0; i < 4; i++) chk($sformatf("t6_data%0d", i), log_data[i], exp6[i]);
        chk("t6_queue_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
